// File: rtl/dmem_access.sv
// dmem_access: load/store sequencer for a word-wide synchronous data RAM.
// Optional DMEM_ALIGN_CHECK_EN enables alignment fault detection.
module dmem_access #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              misalign,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      WR,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              we_q;
   logic [1:0]        size_q;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wd_q;
   logic              req_word;
   logic              req_fault;
   logic              q_byte;
   logic              q_half;
   logic [31:0]       lane_data;
   logic [31:0]       merged;
   logic              unused_addr;

   // addresses alias above the RAM window
   assign unused_addr = ^addr[31:ADDR_W+2];

   assign ram_addr  = addr_q[ADDR_W+1:2];
   assign ram_wdata = wd_q;
   assign q_byte    = (size_q == 2'b10);
   assign q_half    = (size_q == 2'b01);

   // classify the incoming request
   always_comb begin
      req_word  = (size == 2'b00) || (size == 2'b11);
      req_fault = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      req_fault = ((size == 2'b01) && addr[0]) ||
                  (req_word && (addr[1:0] != 2'b00));
`endif
   end

   // lane extraction for loads and merge for partial stores
   always_comb begin
      lane_data = ram_rdata;
      merged    = wd_q;
      unique case (1'b1)
         q_byte: begin
            lane_data = {24'h0, ram_rdata[{addr_q[1:0], 3'b000} +: 8]};
            merged    = ram_rdata;
            merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
         end
         q_half: begin
            lane_data = {16'h0, ram_rdata[{addr_q[1], 4'b0000} +: 16]};
            merged    = ram_rdata;
            merged[{addr_q[1], 4'b0000} +: 16] = wd_q[15:0];
         end
         default: ;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state and RAM strobes
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (req) begin
               if (req_fault)          state_nxt = DONE;
               else if (we && req_word) state_nxt = WR;
               else                    state_nxt = RD;
            end
         end
         RD: begin
            ram_en    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            state_nxt = we_q ? WR : DONE;
         end
         WR: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // request latch, load result and merged store word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q   <= 1'b0;
         size_q <= 2'b00;
         addr_q <= '0;
         wd_q   <= 32'h0;
         rdata  <= 32'h0;
      end else if (state == IDLE && req) begin
         we_q   <= we;
         size_q <= size;
         addr_q <= addr[ADDR_W+1:0];
         wd_q   <= wdata;
      end else if (state == WAIT) begin
         if (!we_q) rdata <= lane_data;
         else       wd_q  <= merged;
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   // fault flag follows each accepted request
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      misalign <= 1'b0;
      else if (state == IDLE && req) misalign <= req_fault;
   end
`else
   assign misalign = 1'b0;
`endif

endmodule
